// File: rtl/iq_samp_rd_ctrl.sv
// iq_samp_rd_ctrl: arbitrates two requesters (host, stream) onto the sampler
// read port and streams the requested IQ pairs out as I,Q,I,Q,... words.
//
// Output handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high. While out_valid is high and out_ready is low,
// out_data/out_last/out_id hold stable. out_valid never depends on out_ready
// combinationally, and the register reloads in the same cycle it drains.
module iq_samp_rd_ctrl #(
  parameter int A_MSB = 12
) (
  input  logic             rd_clk,
  input  logic             rd_rst,
  input  logic [1:0]       req,
  input  logic [11:0]      req_offset0,
  input  logic [11:0]      req_offset1,
  input  logic [A_MSB+1:0] req_count0,
  input  logic [A_MSB+1:0] req_count1,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_data,
  output logic             out_last,
  output logic             out_id,
  output logic             iq_rd_sync,
  output logic             iq_rd_i,
  output logic             iq_rd_q,
  output logic [11:0]      iq_rd_offset,
  input  logic [15:0]      iq_rd_iq,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RD_I   = 3'd3,
    ST_RD_Q   = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam logic [A_MSB+1:0] CNT_ONE  = {{(A_MSB+1){1'b0}}, 1'b1};
  localparam logic [A_MSB+1:0] CNT_ZERO = '0;

  state_t           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             rr_q, rr_d;
  logic             id_q, id_d;
  logic [11:0]      offset_q, offset_d;
  logic [A_MSB+1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [15:0]      out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             out_id_q, out_id_d;

  logic             can_load;
  logic             load;
  logic             load_last;
  logic             pick;
  logic [A_MSB+1:0] pick_count;
  logic [1:0]       done_c;
  logic             sync_c;
  logic             rd_i_c;
  logic             rd_q_c;

  // Next-state, arbitration, sampler strobes and output-register control.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_d       = rr_q;
    id_d       = id_q;
    offset_d   = offset_q;
    count_d    = count_q;
    done_c     = 2'b00;
    sync_c     = 1'b0;
    rd_i_c     = 1'b0;
    rd_q_c     = 1'b0;
    load       = 1'b0;
    load_last  = 1'b0;
    can_load   = ~out_valid_q | out_ready;
    // Both requesting: the round-robin pointer decides; otherwise the lone one.
    pick       = (req == 2'b11) ? rr_q : req[1];
    pick_count = pick ? req_count1 : req_count0;

    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          id_d     = pick;
          gnt_d    = pick ? 2'b10 : 2'b01;
          rr_d     = ~pick;
          offset_d = pick ? req_offset1 : req_offset0;
          count_d  = pick_count;
          state_d  = (pick_count == CNT_ZERO) ? ST_DONE : ST_SYNC;
        end
      end
      ST_SYNC: begin
        sync_c  = 1'b1;
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        state_d = ST_RD_I;
      end
      ST_RD_I: begin
        rd_i_c = 1'b1;
        if (can_load) begin
          load    = 1'b1;
          state_d = ST_RD_Q;
        end
      end
      ST_RD_Q: begin
        if (can_load) begin
          load    = 1'b1;
          rd_q_c  = 1'b1;
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            load_last = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_RD_I;
          end
        end
      end
      ST_DONE: begin
        // No load happens here, so can_load means the last word has drained.
        if (can_load) begin
          done_c  = id_q ? 2'b10 : 2'b01;
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    out_valid_d = load ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = load ? iq_rd_iq  : out_data_q;
    out_last_d  = load ? load_last : out_last_q;
    out_id_d    = load ? id_q      : out_id_q;
  end

  // State, transfer context and output register.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 2'b00;
      rr_q        <= 1'b0;
      id_q        <= 1'b0;
      offset_q    <= 12'd0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 16'd0;
      out_last_q  <= 1'b0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_q        <= rr_d;
      id_q        <= id_d;
      offset_q    <= offset_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
    end
  end

  assign gnt          = gnt_q;
  assign done         = done_c;
  assign busy         = (state_q != ST_IDLE);
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign out_id       = out_id_q;
  assign iq_rd_sync   = sync_c;
  assign iq_rd_i      = rd_i_c;
  assign iq_rd_q      = rd_q_c;
  assign iq_rd_offset = offset_q;
  assign dbg_state    = state_q;

endmodule

// File: doc/iq_samp_rd_ctrl.md
IQ_SAMP_RD_CTRL -- requirements
Module: iq_samp_rd_ctrl

Interface
REQ-001 SHALL have parameter A_MSB, default 12, sampler address MSB (buffer depth 2^(A_MSB+1) IQ pairs).
REQ-002 SHALL have port rd_clk  in  1  sole clock; all logic on its rising edge (the sampler read-side clock).
REQ-003 SHALL have port rd_rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  in  2  level request per requester (0 = host, 1 = stream); held until matching done.
REQ-005 SHALL have ports req_offset0, req_offset1  in  12 each  look-ahead offset per requester, sampled at grant.
REQ-006 SHALL have ports req_count0, req_count1  in  A_MSB+2 each  IQ pairs to read (0..2^(A_MSB+1)), sampled at grant.
REQ-007 SHALL have port gnt  out  2  one-hot grant, held for the whole transfer.
REQ-008 SHALL have port done  out  2  one-cycle completion pulse, per requester.
REQ-009 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-010 SHALL have ports out_valid (out, 1), out_ready (in, 1), out_data (out, 16), out_last (out, 1), out_id (out, 1)  registered output word stream.
REQ-011 SHALL have ports iq_rd_sync, iq_rd_i, iq_rd_q  out  1 each; iq_rd_offset  out  12; iq_rd_iq  in  16  drive/observe the sampler read port.

Function
REQ-012 SHALL implement states IDLE, SYNC, SETTLE, RD_I, RD_Q, DONE.
REQ-013 IDLE: if any req bit is set, grant round-robin (pointer initialised to requester 0 at reset; after a grant the pointer favours the other requester); latch offset/count/id; go to SYNC, or to DONE if the latched count is 0.
REQ-014 SYNC (1 cycle): iq_rd_sync=1, iq_rd_offset=latched offset; then SETTLE.
REQ-015 SETTLE (1 cycle): all sampler strobes 0, covering the BRAM read latency; then RD_I.
REQ-016 RD_I: iq_rd_i=1 combinationally. When the output register can load (~out_valid | out_ready), load out_data=iq_rd_iq, out_last=0, out_id=id, and go to RD_Q. Otherwise stay.
REQ-017 RD_Q: iq_rd_i=0. When the output register can load, load the Q word, pulse iq_rd_q=1 in that same cycle, and decrement the remaining count. Go to DONE if the remaining count was 1 (out_last=1), else to RD_I. iq_rd_q SHALL be 0 on any stalled cycle.
REQ-018 DONE: wait until out_valid=0, or until out_valid & out_ready with no new load. Then pulse done[id] for one cycle, drop gnt, return to IDLE.
REQ-019 Output register: out_valid is set on load, and cleared on out_ready when there is no load that cycle. Words hold stable while out_valid & ~out_ready.
REQ-020 Latency: req seen in IDLE at cycle T gives gnt and iq_rd_sync at T+1, SETTLE at T+2, and the first I word with out_valid=1 at T+4 (out_ready held high).
REQ-021 With out_ready held high, throughput SHALL be one word per cycle, with no bubble between a pair's Q and the next pair's I.
REQ-022 Word order SHALL be I0, Q0, I1, Q1, ... starting at the sampler address wr_addr+offset. Addresses wrap modulo 2^(A_MSB+1), with no special handling in the controller.
REQ-023 Count arithmetic SHALL be unsigned A_MSB+2 bits. The maximum count reads the full buffer exactly once.
REQ-024 A req bit dropped mid-transfer SHALL NOT abort the transfer. A req still high in IDLE after done SHALL be re-arbitrated normally.
REQ-025 Simultaneous req=2'b11 in IDLE SHALL grant the pointer's requester. The other requester is served next.

Reset
REQ-026 rd_rst SHALL force IDLE, gnt=0, done=0, busy=0, out_valid=0, out_last=0, out_id=0, out_data=0, all sampler strobes 0, iq_rd_offset=0, count=0, and rr pointer=0.
REQ-027 rd_rst mid-transfer SHALL discard the transfer with no done pulse. The first post-reset cycle is IDLE.

Verification
REQ-028 Single host read: req=01, offset=5, count=3, out_ready=1, sampler model pre-filled. Expect 6 words I,Q at addresses wr+5..wr+7, out_last only on word 6, done=01 one cycle, and exactly 3 iq_rd_q pulses.
REQ-029 Backpressure: count=2 with out_ready toggling 1,0,0,1,... Expect no word lost or duplicated, iq_rd_q=0 on every stalled cycle, and data stable while stalled.
REQ-030 Arbitration: req=11 from reset. Expect host granted first, then stream. Then repeat with both requests held: grants alternate 0,1,0,1 and done pulses are one-hot.
REQ-031 Boundaries: count=0 gives done within 2 cycles, no sync, no words. count=8192 with offset=4095 wraps the address and yields 16384 words.
REQ-032 Reset mid-operation: rd_rst asserted in RD_Q of a count=4 read. Next cycle all outputs are at reset values, no done pulse, and a following request completes normally.
